// File: rtl/adi_spi_slave_engine.sv
// Multi-lane SPI slave that oversamples SCLK/CS/MOSI on the system clock and
// exchanges DATA_WIDTH-bit words per lane through valid/ready TX and RX streams.
module adi_spi_slave_engine #(
    parameter int          NUM_OF_LANES      = 1,
    parameter int          DATA_WIDTH        = 16,
    parameter int          CPOL              = 0,
    parameter int          CPHA              = 0,
    parameter int          INV_CS            = 0,
    parameter logic [31:0] DEFAULT_MISO_DATA = 32'hCAFE
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 spi_sclk,
    input  logic                                 spi_cs,
    input  logic [NUM_OF_LANES-1:0]              spi_mosi,
    output logic [NUM_OF_LANES-1:0]              spi_miso,
    output logic                                 spi_miso_en,
    input  logic                                 s_tx_valid,
    output logic                                 s_tx_ready,
    input  logic [NUM_OF_LANES*DATA_WIDTH-1:0]   s_tx_data,
    output logic                                 m_rx_valid,
    input  logic                                 m_rx_ready,
    output logic [NUM_OF_LANES*DATA_WIDTH-1:0]   m_rx_data,
    output logic                                 rx_overflow,
    output logic                                 tx_underflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic SCLK_IDLE = (CPOL != 0);
    localparam logic CS_IDLE   = (INV_CS == 0);

    typedef logic [NUM_OF_LANES-1:0][DATA_WIDTH-1:0] lanes_t;
    typedef enum logic {IDLE, SHIFT} state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q;
    logic [NUM_OF_LANES-1:0] mosi_s1_q, mosi_s2_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             need_load_q, need_load_d;
    lanes_t           tx_shift_q, tx_shift_d;
    lanes_t           rx_shift_q, rx_shift_d;
    lanes_t           hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             tx_ready_q;
    lanes_t           rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ovf_q, rx_ovf_d;
    logic             tx_unf_q, tx_unf_d;

    logic cs_act, lead_edge, trail_edge, sample_edge, shift_edge;
    logic load, shift, word_done;

    // Synchronisers start at the idle levels so reset release never looks like an edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_s1_q <= SCLK_IDLE;
            sclk_s2_q <= SCLK_IDLE;
            sclk_s3_q <= SCLK_IDLE;
            cs_s1_q   <= CS_IDLE;
            cs_s2_q   <= CS_IDLE;
            mosi_s1_q <= '0;
            mosi_s2_q <= '0;
        end else begin
            sclk_s1_q <= spi_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= spi_cs;
            cs_s2_q   <= cs_s1_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign cs_act      = (cs_s2_q != CS_IDLE);
    assign lead_edge   = (sclk_s2_q != SCLK_IDLE) && (sclk_s3_q == SCLK_IDLE);
    assign trail_edge  = (sclk_s2_q == SCLK_IDLE) && (sclk_s3_q != SCLK_IDLE);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        need_load_d = need_load_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_ovf_d    = 1'b0;
        tx_unf_d    = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        word_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_act) begin
                    state_d     = SHIFT;
                    bit_cnt_d   = '0;
                    need_load_d = (CPHA != 0);
                    load        = (CPHA == 0);
                end
            end
            SHIFT: begin
                if (!cs_act) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    need_load_d = 1'b0;
                end else begin
                    if (sample_edge) begin
                        for (int l = 0; l < NUM_OF_LANES; l++)
                            rx_shift_d[l] = {rx_shift_q[l][DATA_WIDTH-2:0], mosi_s2_q[l]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d   = '0;
                            need_load_d = 1'b1;
                            word_done   = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        load        = need_load_q;
                        shift       = !need_load_q;
                        need_load_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load frees the holding register in the same cycle a new word may be written
        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                for (int l = 0; l < NUM_OF_LANES; l++)
                    tx_shift_d[l] = DEFAULT_MISO_DATA[DATA_WIDTH-1:0];
                tx_unf_d = 1'b1;
            end
        end else if (shift) begin
            for (int l = 0; l < NUM_OF_LANES; l++)
                tx_shift_d[l] = {tx_shift_q[l][DATA_WIDTH-2:0], 1'b0};
        end
        if (s_tx_valid && tx_ready_q) begin
            hold_d      = s_tx_data;
            hold_full_d = 1'b1;
        end

        if (rx_valid_q && m_rx_ready)
            rx_valid_d = 1'b0;
        if (word_done) begin
            rx_data_d  = rx_shift_d;
            rx_ovf_d   = rx_valid_q && !m_rx_ready;
            rx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            need_load_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_unf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            need_load_q <= need_load_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_ready_q  <= !hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_unf_q    <= tx_unf_d;
        end
    end

    always_comb begin
        spi_miso = '0;
        for (int l = 0; l < NUM_OF_LANES; l++)
            spi_miso[l] = tx_shift_q[l][DATA_WIDTH-1];
    end

    assign spi_miso_en  = (state_q == SHIFT);
    assign s_tx_ready   = tx_ready_q;
    assign m_rx_valid   = rx_valid_q;
    assign m_rx_data    = rx_data_q;
    assign rx_overflow  = rx_ovf_q;
    assign tx_underflow = tx_unf_q;

endmodule

// File: tb/tb_adi_spi_slave_engine.sv
// Directed bench for adi_spi_slave_engine: a bit-banged SPI master drives seven
// differently configured slave instances, one chip select per instance.
module tb_adi_spi_slave_engine;

    localparam int N = 7;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic         sclk_b = 1'b0;
    logic [N-1:0] csn = '1;
    logic [3:0]   mosi_bus = '0;
    logic [31:0]  txd = '0;
    logic [N-1:0] txv = '0;
    logic [N-1:0] rxr = '0;

    logic [N-1:0] miso, men, trdy, rxv, ovf, unf;
    logic [3:0]   miso5;
    logic [15:0]  rx0, rx6;
    logic [7:0]   rx1, rx2, rx3, rx4;
    logic [31:0]  rx5;
    assign miso[5] = miso5[0];

    int checks = 0;
    int errors = 0;
    int unf_cnt[N];
    int ovf_cnt[N];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (unf[k]) unf_cnt[k] <= unf_cnt[k] + 1;
            if (ovf[k]) ovf_cnt[k] <= ovf_cnt[k] + 1;
        end
    end

    adi_spi_slave_engine #(.NUM_OF_LANES(1), .DATA_WIDTH(16), .CPOL(0), .CPHA(0), .INV_CS(0)) u0 (
        .clk(clk), .resetn(resetn), .spi_sclk(sclk_b), .spi_cs(csn[0]), .spi_mosi(mosi_bus[0]),
        .spi_miso(miso[0]), .spi_miso_en(men[0]), .s_tx_valid(txv[0]), .s_tx_ready(trdy[0]),
        .s_tx_data(txd[15:0]), .m_rx_valid(rxv[0]), .m_rx_ready(rxr[0]), .m_rx_data(rx0),
        .rx_overflow(ovf[0]), .tx_underflow(unf[0]));

    adi_spi_slave_engine #(.NUM_OF_LANES(1), .DATA_WIDTH(8), .CPOL(0), .CPHA(1), .INV_CS(0)) u1 (
        .clk(clk), .resetn(resetn), .spi_sclk(sclk_b), .spi_cs(csn[1]), .spi_mosi(mosi_bus[0]),
        .spi_miso(miso[1]), .spi_miso_en(men[1]), .s_tx_valid(txv[1]), .s_tx_ready(trdy[1]),
        .s_tx_data(txd[7:0]), .m_rx_valid(rxv[1]), .m_rx_ready(rxr[1]), .m_rx_data(rx1),
        .rx_overflow(ovf[1]), .tx_underflow(unf[1]));

    adi_spi_slave_engine #(.NUM_OF_LANES(1), .DATA_WIDTH(8), .CPOL(1), .CPHA(0), .INV_CS(0)) u2 (
        .clk(clk), .resetn(resetn), .spi_sclk(~sclk_b), .spi_cs(csn[2]), .spi_mosi(mosi_bus[0]),
        .spi_miso(miso[2]), .spi_miso_en(men[2]), .s_tx_valid(txv[2]), .s_tx_ready(trdy[2]),
        .s_tx_data(txd[7:0]), .m_rx_valid(rxv[2]), .m_rx_ready(rxr[2]), .m_rx_data(rx2),
        .rx_overflow(ovf[2]), .tx_underflow(unf[2]));

    adi_spi_slave_engine #(.NUM_OF_LANES(1), .DATA_WIDTH(8), .CPOL(1), .CPHA(1), .INV_CS(0)) u3 (
        .clk(clk), .resetn(resetn), .spi_sclk(~sclk_b), .spi_cs(csn[3]), .spi_mosi(mosi_bus[0]),
        .spi_miso(miso[3]), .spi_miso_en(men[3]), .s_tx_valid(txv[3]), .s_tx_ready(trdy[3]),
        .s_tx_data(txd[7:0]), .m_rx_valid(rxv[3]), .m_rx_ready(rxr[3]), .m_rx_data(rx3),
        .rx_overflow(ovf[3]), .tx_underflow(unf[3]));

    adi_spi_slave_engine #(.NUM_OF_LANES(1), .DATA_WIDTH(8), .CPOL(0), .CPHA(0), .INV_CS(1)) u4 (
        .clk(clk), .resetn(resetn), .spi_sclk(sclk_b), .spi_cs(~csn[4]), .spi_mosi(mosi_bus[0]),
        .spi_miso(miso[4]), .spi_miso_en(men[4]), .s_tx_valid(txv[4]), .s_tx_ready(trdy[4]),
        .s_tx_data(txd[7:0]), .m_rx_valid(rxv[4]), .m_rx_ready(rxr[4]), .m_rx_data(rx4),
        .rx_overflow(ovf[4]), .tx_underflow(unf[4]));

    adi_spi_slave_engine #(.NUM_OF_LANES(4), .DATA_WIDTH(8), .CPOL(0), .CPHA(0), .INV_CS(0)) u5 (
        .clk(clk), .resetn(resetn), .spi_sclk(sclk_b), .spi_cs(csn[5]), .spi_mosi(mosi_bus),
        .spi_miso(miso5), .spi_miso_en(men[5]), .s_tx_valid(txv[5]), .s_tx_ready(trdy[5]),
        .s_tx_data(txd), .m_rx_valid(rxv[5]), .m_rx_ready(rxr[5]), .m_rx_data(rx5),
        .rx_overflow(ovf[5]), .tx_underflow(unf[5]));

    adi_spi_slave_engine #(.NUM_OF_LANES(1), .DATA_WIDTH(16), .CPOL(0), .CPHA(1), .INV_CS(0)) u6 (
        .clk(clk), .resetn(resetn), .spi_sclk(sclk_b), .spi_cs(csn[6]), .spi_mosi(mosi_bus[0]),
        .spi_miso(miso[6]), .spi_miso_en(men[6]), .s_tx_valid(txv[6]), .s_tx_ready(trdy[6]),
        .s_tx_data(txd[15:0]), .m_rx_valid(rxv[6]), .m_rx_ready(rxr[6]), .m_rx_data(rx6),
        .rx_overflow(ovf[6]), .tx_underflow(unf[6]));

    function automatic logic [63:0] rx_of(input int s);
        case (s)
            0: return 64'(rx0);
            1: return 64'(rx1);
            2: return 64'(rx2);
            3: return 64'(rx3);
            4: return 64'(rx4);
            5: return 64'(rx5);
            6: return 64'(rx6);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [3:0] miso_of(input int s);
        if (s == 5) return miso5;
        return {3'b000, miso[s]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int s, input logic [31:0] d);
        int t;
        t = 0;
        while (!trdy[s] && t < 50) begin
            clks(1);
            t++;
        end
        chk($sformatf("tx_ready_wait%0d", s), 64'(trdy[s]), 64'd1);
        txd    = d;
        txv[s] = 1'b1;
        clks(1);
        txv[s] = 1'b0;
    endtask

    task automatic ack(input int s);
        rxr[s] = 1'b1;
        clks(1);
        rxr[s] = 1'b0;
    endtask

    task automatic cs_on(input int s);
        csn[s] = 1'b0;
        clks(6);
    endtask

    task automatic cs_off(input int s);
        clks(6);
        csn[s] = 1'b1;
        clks(8);
    endtask

    // Master side of one word: nb bits, MSB first, 6-clk SCLK phases
    task automatic word(input int s, input bit cpha, input int dw, input int nb,
                        input logic [127:0] mo, output logic [127:0] mi);
        logic [31:0] acc;
        logic [3:0]  m;
        int b;
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            b = dw - 1 - i;
            if (!cpha) begin
                for (int l = 0; l < 4; l++) mosi_bus[l] = mo[l*32 + b];
                clks(6);
                sclk_b = 1'b1;
                m = miso_of(s);
            end else begin
                sclk_b = 1'b1;
                for (int l = 0; l < 4; l++) mosi_bus[l] = mo[l*32 + b];
                clks(6);
                sclk_b = 1'b0;
                m = miso_of(s);
            end
            for (int l = 0; l < 4; l++) begin
                acc = mi[l*32 +: 32];
                acc = {acc[30:0], m[l]};
                mi[l*32 +: 32] = acc;
            end
            clks(6);
            if (!cpha) sclk_b = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] mi;
        int u_base, o_base;
        bit cpha;

        #2 resetn = 1'b0;
        clks(3);
        chk("rst_miso_en", 64'(men), 64'd0);
        chk("rst_tx_ready", 64'(trdy), 64'd0);
        chk("rst_rx_valid", 64'(rxv), 64'd0);
        chk("rst_miso", 64'(miso), 64'd0);
        resetn = 1'b1;
        clks(1);
        chk("tx_ready_after_release", 64'(trdy), 64'h7F);
        chk("idle_miso_en", 64'(men), 64'd0);

        push(0, 32'h1234);
        cs_on(0);
        chk("mode0_miso_en", 64'(men[0]), 64'd1);
        word(0, 1'b0, 16, 16, 128'hA5C3, mi);
        cs_off(0);
        chk("mode0_miso", 64'(mi[15:0]), 64'h1234);
        chk("mode0_rx_data", rx_of(0), 64'hA5C3);
        chk("mode0_rx_valid", 64'(rxv[0]), 64'd1);
        chk("mode0_no_overflow", 64'(ovf_cnt[0]), 64'd0);
        chk("mode0_miso_en_off", 64'(men[0]), 64'd0);
        ack(0);
        chk("mode0_rx_consumed", 64'(rxv[0]), 64'd0);

        push(0, 32'h9ABC);
        cs_on(0);
        push(0, 32'h5566);
        word(0, 1'b0, 16, 5, 128'hFFFF, mi);
        cs_off(0);
        chk("abort_miso_bits", 64'(mi[4:0]), 64'h13);
        chk("abort_no_rx", 64'(rxv[0]), 64'd0);
        chk("abort_hold_kept", 64'(trdy[0]), 64'd0);
        cs_on(0);
        word(0, 1'b0, 16, 16, 128'h0F0F, mi);
        cs_off(0);
        chk("after_abort_miso", 64'(mi[15:0]), 64'h5566);
        chk("after_abort_rx_data", rx_of(0), 64'h0F0F);
        chk("after_abort_rx_valid", 64'(rxv[0]), 64'd1);

        push(0, 32'h4321);
        cs_on(0);
        word(0, 1'b0, 16, 6, 128'hFFFF, mi);
        resetn = 1'b0;
        #1;
        chk("rst_mid_miso_en", 64'(men[0]), 64'd0);
        chk("rst_mid_rx_valid", 64'(rxv[0]), 64'd0);
        chk("rst_mid_rx_data", rx_of(0), 64'd0);
        chk("rst_mid_tx_ready", 64'(trdy[0]), 64'd0);
        chk("rst_mid_miso", 64'(miso[0]), 64'd0);
        chk("rst_mid_flags", 64'({ovf, unf}), 64'd0);
        csn[0] = 1'b1;
        mosi_bus = '0;
        clks(3);
        resetn = 1'b1;
        clks(1);
        chk("rst_mid_tx_ready_release", 64'(trdy[0]), 64'd1);
        push(0, 32'hBEEF);
        cs_on(0);
        word(0, 1'b0, 16, 16, 128'h1357, mi);
        cs_off(0);
        chk("post_rst_miso", 64'(mi[15:0]), 64'hBEEF);
        chk("post_rst_rx_data", rx_of(0), 64'h1357);
        ack(0);

        for (int s = 1; s <= 4; s++) begin
            cpha = (s == 1) || (s == 3);
            push(s, 32'h5A);
            cs_on(s);
            word(s, cpha, 8, 8, 128'h5A, mi);
            cs_off(s);
            chk($sformatf("echo%0d_miso", s), 64'(mi[7:0]), 64'h5A);
            chk($sformatf("echo%0d_rx_data", s), rx_of(s), 64'h5A);
            chk($sformatf("echo%0d_rx_valid", s), 64'(rxv[s]), 64'd1);
            ack(s);
            push(s, 32'h17);
            cs_on(s);
            word(s, cpha, 8, 8, 128'hB4, mi);
            cs_off(s);
            chk($sformatf("order%0d_miso", s), 64'(mi[7:0]), 64'h17);
            chk($sformatf("order%0d_rx_data", s), rx_of(s), 64'hB4);
            ack(s);
        end

        push(5, 32'h11223344);
        cs_on(5);
        word(5, 1'b0, 8, 8, {32'hDD, 32'hCC, 32'hBB, 32'hAA}, mi);
        cs_off(5);
        chk("lane0_miso", 64'(mi[7:0]), 64'h44);
        chk("lane1_miso", 64'(mi[39:32]), 64'h33);
        chk("lane2_miso", 64'(mi[71:64]), 64'h22);
        chk("lane3_miso", 64'(mi[103:96]), 64'h11);
        chk("lanes_rx_data", rx_of(5), 64'hDDCCBBAA);
        chk("lanes_rx_valid", 64'(rxv[5]), 64'd1);

        u_base = unf_cnt[6];
        o_base = ovf_cnt[6];
        cs_on(6);
        word(6, 1'b1, 16, 16, 128'h1111, mi);
        chk("unf_word1_miso", 64'(mi[15:0]), 64'hCAFE);
        word(6, 1'b1, 16, 16, 128'h2222, mi);
        chk("unf_word2_miso", 64'(mi[15:0]), 64'hCAFE);
        word(6, 1'b1, 16, 16, 128'h3333, mi);
        chk("unf_word3_miso", 64'(mi[15:0]), 64'hCAFE);
        cs_off(6);
        chk("underflow_count", 64'(unf_cnt[6] - u_base), 64'd3);
        chk("overflow_count", 64'(ovf_cnt[6] - o_base), 64'd2);
        chk("ovf_rx_data_last", rx_of(6), 64'h3333);
        chk("ovf_rx_valid", 64'(rxv[6]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
